// File: rtl/gb80_mem_ctrl.sv
// gb80 memory bus controller: wait-stated ROM/RAM/OAM bus cycles for the
// processor port, plus the OAM DMA engine triggered by a write to DMA_REG_ADDR.
module gb80_mem_ctrl #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    WAIT_STATES  = 1,
  parameter int                    DMA_LEN      = 160,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [ADDR_WIDTH-1:0] OAM_BASE     = 16'hFE00
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  input  logic                  i_cpu_rd,
  input  logic                  i_cpu_wr,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_busy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_DMA_RD,
    S_DMA_WR
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);
  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);

  state_t                state, state_d;
  logic [2:0]            wait_cnt, wait_cnt_d;
  logic [7:0]            dma_idx, dma_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  is_wr;
  logic                  dma_pend;
  logic [DATA_WIDTH-1:0] src_hi;
  logic [DATA_WIDTH-1:0] dma_buf;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic strobe;
  logic dma_trig;
  logic phase_last;

  assign strobe     = i_cpu_rd | i_cpu_wr;
  // A write wins over a simultaneous read, so rd+wr to the DMA register triggers DMA.
  assign dma_trig   = i_cpu_wr && (i_cpu_addr == DMA_REG_ADDR);
  assign phase_last = (wait_cnt == 3'd0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    dma_idx_d  = dma_idx;
    case (state)
      S_IDLE: begin
        if (strobe) begin
          if (dma_trig) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ACCESS;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      S_ACCESS: begin
        if (phase_last) state_d = S_DONE;
        else            wait_cnt_d = wait_cnt - 3'd1;
      end
      S_DONE: begin
        if (dma_pend) begin
          state_d    = S_DMA_RD;
          wait_cnt_d = WAIT_INIT;
          dma_idx_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DMA_RD: begin
        if (phase_last) begin
          state_d    = S_DMA_WR;
          wait_cnt_d = WAIT_INIT;
        end else begin
          wait_cnt_d = wait_cnt - 3'd1;
        end
      end
      S_DMA_WR: begin
        if (phase_last) begin
          wait_cnt_d = WAIT_INIT;
          if (dma_idx == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DMA_RD;
            dma_idx_d = dma_idx + 8'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      dma_idx  <= 8'd0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      dma_idx  <= dma_idx_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      is_wr    <= 1'b0;
      dma_pend <= 1'b0;
      src_hi   <= '0;
      dma_buf  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == S_IDLE && strobe) begin
        addr_q   <= i_cpu_addr;
        wdata_q  <= i_cpu_wdata;
        is_wr    <= i_cpu_wr;
        dma_pend <= dma_trig;
        if (dma_trig) src_hi <= i_cpu_wdata;
      end
      if (state == S_DONE) dma_pend <= 1'b0;
      if (state == S_ACCESS && phase_last && !is_wr) rdata_q <= i_mem_rdata;
      if (state == S_DMA_RD && phase_last) dma_buf <= i_mem_rdata;
    end
  end

  // Bus outputs are decoded from state, so reset forces them low immediately.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    case (state)
      S_ACCESS: begin
        o_mem_addr  = addr_q;
        o_mem_rd    = !is_wr;
        o_mem_wr    = is_wr;
        o_mem_wdata = is_wr ? wdata_q : '0;
      end
      S_DMA_RD: begin
        o_mem_addr = ADDR_WIDTH'({src_hi, dma_idx});
        o_mem_rd   = 1'b1;
      end
      S_DMA_WR: begin
        o_mem_addr  = OAM_BASE + ADDR_WIDTH'(dma_idx);
        o_mem_wdata = dma_buf;
        o_mem_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdata  = rdata_q;
  assign o_cpu_ready  = (state == S_DONE);
  assign o_dma_active = (state == S_DMA_RD) || (state == S_DMA_WR);
  assign o_cpu_busy   = (state != S_IDLE) || o_dma_active;

endmodule

// File: tb/tb_gb80_mem_ctrl.sv
// Randomized bench for gb80_mem_ctrl: a transaction monitor collapses bus activity
// into beats, and a reference model predicts beats, latency and read data per request.
module tb_gb80_mem_ctrl;

  localparam int          W       = 1;
  localparam int          LEN     = 160;
  localparam logic [15:0] DMA_REG = 16'hFF46;
  localparam logic [15:0] OAM     = 16'hFE00;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
  } beat_t;

  logic        clk;
  logic        i_reset;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        i_cpu_rd;
  logic        i_cpu_wr;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_ready;
  logic        o_cpu_busy;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [7:0]  i_mem_rdata;
  logic        o_dma_active;

  logic [7:0]  bus_mem [0:65535];

  gb80_mem_ctrl #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (8),
    .WAIT_STATES (W),
    .DMA_LEN     (LEN),
    .DMA_REG_ADDR(DMA_REG),
    .OAM_BASE    (OAM)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .i_cpu_rd    (i_cpu_rd),
    .i_cpu_wr    (i_cpu_wr),
    .o_cpu_rdata (o_cpu_rdata),
    .o_cpu_ready (o_cpu_ready),
    .o_cpu_busy  (o_cpu_busy),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .i_mem_rdata (i_mem_rdata),
    .o_dma_active(o_dma_active)
  );

  // Read-only external memory image; writes are observed on the bus, not stored.
  assign i_mem_rdata = o_mem_rd ? bus_mem[o_mem_addr] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t beats[$];
  int    ready_q[$];
  int    dma_cycles  = 0;
  int    both_cycles = 0;

  initial begin : monitor
    bit    prev_act;
    beat_t cur;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (o_mem_rd && o_mem_wr) both_cycles++;
      if (o_mem_rd || o_mem_wr) begin
        if (prev_act && beats.size() > 0 &&
            beats[beats.size()-1].wr == o_mem_wr &&
            beats[beats.size()-1].addr == o_mem_addr &&
            beats[beats.size()-1].data == o_mem_wdata) begin
          cur = beats.pop_back();
          cur.len++;
          beats.push_back(cur);
        end else begin
          cur.wr   = o_mem_wr;
          cur.addr = o_mem_addr;
          cur.data = o_mem_wdata;
          cur.len  = 1;
          beats.push_back(cur);
        end
        prev_act = 1'b1;
      end else begin
        prev_act = 1'b0;
      end
      if (o_cpu_ready)  ready_q.push_back(cyc);
      if (o_dma_active) dma_cycles++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit wr, input logic [15:0] a,
                                       input logic [7:0] d, input int len);
    return {wr, a, d, 7'(len)};
  endfunction

  function automatic logic [31:0] pack_beat(input beat_t b);
    return pack(b.wr, b.addr, b.data, b.len);
  endfunction

  logic [7:0] exp_rdata;

  // Expected DMA traffic: transfer i reads {src,i} and writes that byte to OAM+i.
  task automatic check_dma_beats(input int b0, input logic [7:0] src, input int n);
    logic [15:0] sa;
    for (int i = 0; i < n && b0 + 2*i + 1 < beats.size(); i++) begin
      sa = {src, 8'(i)};
      check("dma_rd_beat", pack_beat(beats[b0 + 2*i]), pack(1'b0, sa, 8'h00, W + 1));
      check("dma_wr_beat", pack_beat(beats[b0 + 2*i + 1]),
            pack(1'b1, OAM + 16'(i), bus_mem[sa], W + 1));
    end
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [7:0] d, input bit inject);
    int s, b0, r0, dc0;
    bit dma;
    dma = wr && (a == DMA_REG);
    @(negedge clk); #1;
    b0  = beats.size();
    r0  = ready_q.size();
    dc0 = dma_cycles;
    s   = cyc;
    i_cpu_rd = rd; i_cpu_wr = wr; i_cpu_addr = a; i_cpu_wdata = d;
    @(negedge clk); #1;
    i_cpu_rd = 1'b0; i_cpu_wr = 1'b0;
    i_cpu_addr = 16'($urandom); i_cpu_wdata = 8'($urandom);
    if (inject && !dma) begin
      i_cpu_rd = 1'b1;
      @(negedge clk); #1;
      i_cpu_rd = 1'b0;
    end
    for (int k = 0; k < 50 && ready_q.size() == r0; k++) begin
      @(negedge clk); #1;
    end
    check("ready_seen", 32'(ready_q.size() > r0), 32'd1);
    if (dma) begin
      for (int k = 0; k < 4 * LEN * (W + 1); k++) begin
        @(negedge clk); #1;
        if (inject && k == 200) begin
          i_cpu_rd   = 1'b1;
          i_cpu_addr = 16'($urandom);
        end
        if (k == 201) i_cpu_rd = 1'b0;
        if (!o_dma_active) break;
      end
      check("dma_finished", 32'(o_dma_active), 32'd0);
    end
    @(negedge clk); #1;
    check("ready_count", 32'(ready_q.size() - r0), 32'd1);
    if (ready_q.size() > r0) check("latency", 32'(ready_q[r0] - s), dma ? 32'd1 : 32'(W + 2));
    check("busy_idle", 32'(o_cpu_busy), 32'd0);
    if (!dma) begin
      check("beat_count", 32'(beats.size() - b0), 32'd1);
      if (beats.size() > b0)
        check("beat", pack_beat(beats[b0]), pack(wr, a, wr ? d : 8'h00, W + 1));
      if (!wr) exp_rdata = bus_mem[a];
      check("rdata", 32'(o_cpu_rdata), 32'(exp_rdata));
    end else begin
      check("dma_beat_count", 32'(beats.size() - b0), 32'(2 * LEN));
      check("dma_cycles", 32'(dma_cycles - dc0), 32'(2 * (W + 1) * LEN));
      check_dma_beats(b0, d, LEN);
      check("rdata_kept", 32'(o_cpu_rdata), 32'(exp_rdata));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus"}, {o_mem_addr, o_mem_wdata, 6'd0, o_mem_rd, o_mem_wr}, 32'd0);
    check({tag, "_cpu"}, {21'd0, o_cpu_rdata, o_cpu_ready, o_cpu_busy, o_dma_active}, 32'd0);
  endtask

  task automatic reset_mid_dma(input logic [7:0] src);
    int b0;
    @(negedge clk); #1;
    b0 = beats.size();
    i_cpu_wr = 1'b1; i_cpu_addr = DMA_REG; i_cpu_wdata = src;
    @(negedge clk); #1;
    i_cpu_wr = 1'b0;
    // Stop when the read of transfer 40 first appears on the bus.
    for (int k = 0; k < 1000 && beats.size() < b0 + 81; k++) begin
      @(negedge clk); #1;
    end
    check("rst_reached_t40", 32'(beats.size() >= b0 + 81), 32'd1);
    i_reset = 1'b0;
    #1;
    check_all_zero("rst_immediate");
    exp_rdata = 8'h00;
    check_dma_beats(b0, src, 40);
    if (beats.size() > b0 + 80)
      check("rst_t40_rd", {15'd0, beats[b0 + 80].addr, 1'b0}, {15'd0, src, 8'd40, 1'b0});
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("rst_held");
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst_released");
    do_op(1'b1, 1'b0, 16'($urandom), 8'h00, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] a;
    int          kind;
    i_reset = 1'b0;
    i_cpu_rd = 1'b0; i_cpu_wr = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) bus_mem[i] = 8'($urandom);
    bus_mem[16'h0150] = 8'h3E;
    exp_rdata = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    i_reset = 1'b1;

    do_op(1'b1, 1'b0, 16'h0150, 8'h00, 1'b0);
    check("read_0150", 32'(o_cpu_rdata), 32'h3E);
    do_op(1'b0, 1'b1, 16'hC000, 8'h5A, 1'b0);
    do_op(1'b0, 1'b1, DMA_REG, 8'hC1, 1'b0);
    do_op(1'b1, 1'b0, 16'($urandom), 8'h00, 1'b1);
    do_op(1'b1, 1'b1, 16'hD000, 8'h77, 1'b0);
    do_op(1'b1, 1'b0, DMA_REG, 8'h00, 1'b0);
    do_op(1'b0, 1'b1, DMA_REG, 8'($urandom), 1'b1);
    do_op(1'b0, 1'b1, DMA_REG, 8'hFE, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = 16'($urandom);
      if (kind != 0 && a == DMA_REG) a = 16'hC000;
      do_op(kind != 1, kind != 0, a, 8'($urandom), 1'($urandom));
    end

    reset_mid_dma(8'h80);
    check("no_rd_wr_overlap", 32'(both_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb80_mem_ctrl.md
Name: gb80_mem_ctrl

Overview:
- Memory bus controller between the gb80 processor memory port and the external ROM/RAM/OAM bus.
- Turns single-cycle processor read/write strobes into wait-stated bus cycles and returns read data with a ready pulse.
- Contains the OAM DMA engine: a write to the DMA register copies DMA_LEN bytes from {src_hi, 8'h00} to OAM_BASE.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 8, data width.
- WAIT_STATES, 1, extra bus cycles per access (W); range 0..7.
- DMA_LEN, 160, bytes per DMA transfer; range 1..256.
- DMA_REG_ADDR, 16'hFF46, address of the DMA trigger register.
- OAM_BASE, 16'hFE00, DMA destination base.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active-low.
- i_cpu_addr  in  ADDR_WIDTH  processor address.
- i_cpu_wdata  in  DATA_WIDTH  processor write data.
- i_cpu_rd  in  1  one-cycle read strobe.
- i_cpu_wr  in  1  one-cycle write strobe.
- o_cpu_rdata  out  DATA_WIDTH  registered read data.
- o_cpu_ready  out  1  one-cycle completion pulse.
- o_cpu_busy  out  1  high while state != IDLE.
- o_mem_addr  out  ADDR_WIDTH  bus address.
- o_mem_wdata  out  DATA_WIDTH  bus write data.
- o_mem_rd  out  1  bus read strobe.
- o_mem_wr  out  1  bus write strobe.
- i_mem_rdata  in  DATA_WIDTH  bus read data.
- o_dma_active  out  1  DMA in progress.

Behaviour:
- Reset (i_reset low, asynchronous): state IDLE; all outputs 0; DMA index 0. Reset mid-access or mid-DMA aborts immediately. No resume after reset.
- States: IDLE, ACCESS, DONE, DMA_RD, DMA_WR. Wait counter is 3 bits.
- Request acceptance:
  - Strobes are sampled only in IDLE with o_dma_active low.
  - Strobes in any other state are dropped. The processor must not strobe while o_cpu_busy is high.
  - i_cpu_rd and i_cpu_wr high together: treated as a write.
- Normal access (address != DMA_REG_ADDR, or any read):
  - Accept edge: latch address, data and direction. Go to ACCESS with counter = W.
  - ACCESS lasts W+1 cycles. o_mem_addr holds the latched address. o_mem_rd or o_mem_wr is high for the whole access. o_mem_wdata holds the latched data on writes and is 0 on reads.
  - On the edge ending the last ACCESS cycle: o_cpu_rdata <= i_mem_rdata on a read (unchanged on a write); state goes to DONE.
  - DONE: strobes low; o_cpu_ready = 1 for exactly one cycle; then IDLE.
  - Latency from strobe cycle to ready cycle: W+2.
- Reads of DMA_REG_ADDR are normal bus reads.
- DMA trigger (write to DMA_REG_ADDR):
  - Not forwarded to the bus. Latch src_hi = i_cpu_wdata; go straight to DONE, so ready comes in the cycle after the strobe.
  - From DONE go to DMA_RD with index 0; o_dma_active = 1 from that cycle.
- DMA transfer:
  - DMA_RD: W+1 cycles with o_mem_rd, address {src_hi, index}. On the last edge, capture i_mem_rdata into the DMA buffer.
  - DMA_WR: W+1 cycles with o_mem_wr, address OAM_BASE + index, data = buffer.
  - After DMA_WR, increment index. If index == DMA_LEN-1, go to IDLE and clear o_dma_active; otherwise go to DMA_RD.
  - Total duration 2*(W+1)*DMA_LEN cycles. Any src_hi value is used verbatim, with no clipping.
- Boundaries:
  - index wraps within 8 bits and never exceeds DMA_LEN-1.
  - With W = 0 each phase is 1 cycle.
  - o_cpu_ready never fires during DMA.
  - o_cpu_busy = (state != IDLE) || o_dma_active.

Test Plan:
- Read, W=1: read strobe, addr 16'h0150, memory returns 8'h3E. Required: o_mem_rd high 2 cycles with addr 0150; ready 3 cycles after strobe; o_cpu_rdata = 8'h3E.
- Write, W=0: write strobe, addr C000, data 5A. Required: o_mem_wr high 1 cycle with C000/5A; ready 2 cycles after strobe; o_cpu_rdata unchanged.
- DMA, W=1: write 8'hC1 to FF46. Required: ready in the next cycle; no bus write to FF46; reads C100..C19F each followed by a write to FE00..FE9F with the same byte; o_dma_active high exactly 640 cycles.
- Strobe during busy: read strobe during ACCESS and during DMA. Required: ignored, no extra bus cycle, no extra ready.
- Simultaneous rd and wr to D000, data 77. Required: one bus write of 77 only.
- Reset mid-DMA: assert i_reset low at transfer 40. Required: all outputs 0 immediately; after release, state is IDLE and the next read completes normally.
